// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Imported by the loader top and its byte packer.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } ld_state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  // one bit wider than the 16-bit length so a full
  // count can be compared and counted without wrap
  localparam int CNT_W          = 17;

endpackage

// File: rtl/byte_packer.sv
// Collects four stream bytes, little-endian, into one word.
// full_o marks the cycle the last byte of a word is accepted.
module byte_packer
  import riscv_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          valid_i,
  input  logic [7:0]    byte_i,
  output logic [DW-1:0] word_o,
  output logic          full_o
);

  localparam int IW = $clog2(BYTES_PER_WORD);

  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_word;

  // merged view includes the byte being accepted now
  always_comb begin
    word_o = r_word;
    word_o[{r_idx, 3'b000} +: 8] = byte_i;
    full_o = valid_i &&
      (r_idx == IW'(BYTES_PER_WORD - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (clr_i) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (valid_i) begin
      r_idx  <= r_idx + 1'b1;
      r_word <= word_o;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into
// instruction memory while holding the core in reset.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int DW             = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  parameter int NO_OF_REGS     = MEM_SIZE_IN_KB*1024/4,
  parameter int ADDRW          = $clog2(NO_OF_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             byte_valid_i,
  input  logic [7:0]       byte_data_i,
  output logic             byte_ready_o,
  output logic             we_o,
  output logic [ADDRW-1:0] waddr_o,
  output logic [DW-1:0]    wdata_o,
  output logic             core_rst_o,
  output logic             done_o,
  output logic             err_o
);

  ld_state_e        r_state;
  ld_state_e        w_next;
  logic [15:0]      r_len;
  logic [CNT_W-1:0] r_widx;
  logic [7:0]       r_csum;
  logic             r_we;
  logic [ADDRW-1:0] r_waddr;
  logic [DW-1:0]    r_wdata;

  logic             w_acc;
  logic             w_start;
  logic [15:0]      w_len;
  logic             w_pk_vld;
  logic [DW-1:0]    w_word;
  logic             w_full;
  logic             w_last;

  assign w_acc    = byte_valid_i && byte_ready_o;
  assign w_start  = start_i &&
    (r_state == IDLE || r_state == DONE ||
     r_state == ERR);
  assign w_len    = {byte_data_i, r_len[7:0]};
  assign w_pk_vld = w_acc && (r_state == DATA);
  assign w_last   = w_full &&
    ((r_widx + CNT_W'(1)) == {1'b0, r_len});

  byte_packer #(.DW(DW)) u_packer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_start),
    .valid_i(w_pk_vld),
    .byte_i (byte_data_i),
    .word_o (w_word),
    .full_o (w_full)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    byte_ready_o = 1'b0;
    core_rst_o   = 1'b1;
    done_o       = 1'b0;
    err_o        = 1'b0;
    unique case (r_state)
      IDLE: if (start_i) w_next = LEN0;
      LEN0: begin
        byte_ready_o = 1'b1;
        if (w_acc) w_next = LEN1;
      end
      LEN1: begin
        byte_ready_o = 1'b1;
        if (w_acc) begin
          if ({1'b0, w_len} > CNT_W'(NO_OF_REGS))
            w_next = ERR;
          else if (w_len == '0)
            w_next = CSUM;
          else
            w_next = DATA;
        end
      end
      DATA: begin
        byte_ready_o = 1'b1;
        if (w_last) w_next = CSUM;
      end
      CSUM: begin
        byte_ready_o = 1'b1;
        if (w_acc)
          w_next = (byte_data_i == r_csum) ? DONE : ERR;
      end
      DONE: begin
        core_rst_o = 1'b0;
        done_o     = 1'b1;
        if (start_i) w_next = LEN0;
      end
      ERR: begin
        err_o = 1'b1;
        if (start_i) w_next = LEN0;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len   <= '0;
      r_widx  <= '0;
      r_csum  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_len  <= '0;
        r_widx <= '0;
        r_csum <= '0;
      end
      if (w_acc && r_state == LEN0)
        r_len[7:0] <= byte_data_i;
      if (w_acc && r_state == LEN1)
        r_len[15:8] <= byte_data_i;
      if (w_pk_vld)
        r_csum <= r_csum ^ byte_data_i;
      // address/data only move on a write
      if (w_full) begin
        r_we    <= 1'b1;
        r_waddr <= r_widx[ADDRW-1:0];
        r_wdata <= w_word;
        r_widx  <= r_widx + CNT_W'(1);
      end
    end
  end

  assign we_o    = r_we;
  assign waddr_o = r_waddr;
  assign wdata_o = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and random loads checked against a stream-level
// model of the image format.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        bv = 1'b0;
  logic [7:0]  bd = 8'h00;
  logic        byte_ready_o;
  logic        we_o;
  logic [7:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        core_rst_o;
  logic        done_o;
  logic        err_o;

  imem_loader dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .byte_valid_i(bv),
    .byte_data_i (bd),
    .byte_ready_o(byte_ready_o),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .core_rst_o  (core_rst_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  logic [7:0]  got_a[$];
  logic [31:0] got_d[$];
  logic [31:0] exp_d[$];
  logic [7:0]  stim[$];
  logic [7:0]  pa = 8'h00;
  logic [31:0] pd = 32'h0;
  logic        prst = 1'b0;

  always @(negedge clk) begin
    if (rst_ni && we_o) begin
      got_a.push_back(waddr_o);
      got_d.push_back(wdata_o);
    end
    if (rst_ni && prst && !we_o) begin
      chk("hold_addr", {56'h0, waddr_o}, {56'h0, pa});
      chk("hold_data", {32'h0, wdata_o}, {32'h0, pd});
    end
    pa   = waddr_o;
    pd   = wdata_o;
    prst = rst_ni;
  end

  // expected writes and outcome straight from the format
  task automatic model(output int nb, output logic ok);
    int len;
    logic [7:0] cs;
    logic [31:0] w;
    exp_d.delete();
    len = int'(stim[0]) | (int'(stim[1]) << 8);
    if (len > 256) begin
      nb = 2;
      ok = 1'b0;
    end else begin
      cs = 8'h00;
      for (int i = 0; i < len; i++) begin
        w = {stim[5+4*i], stim[4+4*i],
             stim[3+4*i], stim[2+4*i]};
        exp_d.push_back(w);
        cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      end
      nb = 3 + 4*len;
      ok = (stim[nb-1] == cs);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int maxgap);
    int n;
    bv = 1'b0;
    repeat ($urandom_range(0, maxgap)) @(negedge clk);
    bv = 1'b1;
    bd = b;
    n  = 0;
    while (!byte_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {63'h0, byte_ready_o}, 64'h1);
    @(negedge clk);
    bv = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic run_load(input string tag,
                          input int maxgap);
    int nb;
    int n;
    logic ok;
    model(nb, ok);
    got_a.delete();
    got_d.delete();
    do_start();
    chk({tag, "_rst_busy"}, {63'h0, core_rst_o}, 64'h1);
    chk({tag, "_ready"}, {63'h0, byte_ready_o}, 64'h1);
    for (int i = 0; i < nb; i++) send_byte(stim[i], maxgap);
    repeat (3) @(negedge clk);
    chk({tag, "_nwr"}, 64'(got_d.size()),
        64'(exp_d.size()));
    n = (got_d.size() < exp_d.size()) ?
        got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_a%0d", tag, i),
          {56'h0, got_a[i]}, 64'(i));
      chk($sformatf("%s_d%0d", tag, i),
          {32'h0, got_d[i]}, {32'h0, exp_d[i]});
    end
    chk({tag, "_done"}, {63'h0, done_o}, {63'h0, ok});
    chk({tag, "_err"}, {63'h0, err_o}, {63'h0, !ok});
    chk({tag, "_crst"}, {63'h0, core_rst_o}, {63'h0, !ok});
    chk({tag, "_idle_rdy"}, {63'h0, byte_ready_o}, 64'h0);
  endtask

  task automatic build(input int len, input bit bad);
    logic [7:0] b;
    logic [7:0] cs;
    stim.delete();
    stim.push_back(8'(len));
    stim.push_back(8'(len >> 8));
    cs = 8'h00;
    for (int i = 0; i < 4*len; i++) begin
      b = 8'($urandom);
      stim.push_back(b);
      cs ^= b;
    end
    if (bad) cs ^= 8'($urandom_range(1, 255));
    stim.push_back(cs);
  endtask

  task automatic set_good(input logic [7:0] last);
    stim = '{8'h02, 8'h00, 8'h93, 8'h01, 8'h40, 8'h00,
             8'h63, 8'hC4, 8'h01, 8'h08, last};
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_crst"}, {63'h0, core_rst_o}, 64'h1);
    chk({tag, "_we"}, {63'h0, we_o}, 64'h0);
    chk({tag, "_rdy"}, {63'h0, byte_ready_o}, 64'h0);
    chk({tag, "_done"}, {63'h0, done_o}, 64'h0);
    chk({tag, "_err"}, {63'h0, err_o}, 64'h0);
    chk({tag, "_addr"}, {56'h0, waddr_o}, 64'h0);
    chk({tag, "_data"}, {32'h0, wdata_o}, 64'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_ni = 1'b1;
    @(negedge clk);

    set_good(8'h7C);
    run_load("good", 0);
    chk("good_w0", {32'h0, got_d.size() > 0 ? got_d[0] : 32'h0},
        64'h00400193);
    chk("good_w1", {32'h0, got_d.size() > 1 ? got_d[1] : 32'h0},
        64'h0801c463);

    set_good(8'h7D);
    run_load("badcs", 0);

    stim = '{8'h00, 8'h00, 8'h00};
    run_load("zero", 0);

    stim = '{8'h01, 8'h01};
    run_load("over", 0);

    set_good(8'h7C);
    run_load("stall", 5);

    set_good(8'h7C);
    do_start();
    for (int i = 0; i < 5; i++) send_byte(stim[i], 1);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    run_load("after_rst", 2);

    for (int k = 0; k < 10; k++) begin
      build($urandom_range(0, 8), $urandom_range(0, 1) == 1);
      run_load($sformatf("rnd%0d", k), 3);
    end

    build(256, 1'b0);
    run_load("full", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
